iso_pwr_ctrl: RTL and testbench
===============================

ISO_PWR_CTRL -- requirements
Module: iso_pwr_ctrl

Interface
REQ-001 Parameter ISO_SETUP, default 4: number of cycles isolation SHALL be held before the power switch is opened (1..255).
REQ-002 Parameter ISO_HOLD, default 4: number of cycles isolation SHALL be held after power-good (1..255).
REQ-003 Parameter ACK_TIMEOUT, default 200: maximum cycles to wait for a power acknowledge (1..255).
REQ-004 The port list SHALL be as follows, one clock, with reset synchronous and active-high:
- CLK  in  1  sole clock; all state updates on the rising edge.
- RST  in  1  synchronous active-high reset.
- PWR_REQ_B  in  1  level request for domain B: 1=on, 0=off.
- PWR_REQ_C  in  1  level request for domain C: 1=on, 0=off.
- PWR_ACK_B  in  1  power-good from the domain B switch.
- PWR_ACK_C  in  1  power-good from the domain C switch.
- CLR_ERR  in  1  single-cycle pulse that clears the error state in both domains.
- ISOB  out  1  isolation enable for domain B outputs; 1=isolated.
- ISOC  out  1  isolation enable for domain C outputs; 1=isolated.
- PWR_EN_B  out  1  power switch enable for domain B.
- PWR_EN_C  out  1  power switch enable for domain C.
- ON_B  out  1  domain B is fully on and de-isolated.
- ON_C  out  1  domain C is fully on and de-isolated.
- BUSY  out  2  {C,B}: the domain is in a transition state.
- ERR  out  2  {C,B}: the domain is in the ERROR state.

Function
REQ-005 Each domain SHALL run an independent FSM with states OFF, UP_WAIT, UP_HOLD, ON, DN_ISO, DN_WAIT, ERROR, and an 8-bit counter CNT.
REQ-006 All outputs SHALL be registered, so each output reflects the state entered at the preceding edge.
REQ-007 Outputs per state SHALL be as follows (ISO / PWR_EN / ON):
- OFF: 1 / 0 / 0.
- UP_WAIT: 1 / 1 / 0.
- UP_HOLD: 1 / 1 / 0.
- ON: 0 / 1 / 1.
- DN_ISO: 1 / 1 / 0.
- DN_WAIT: 1 / 0 / 0.
- ERROR: 1 / 0 / 0.
REQ-008 BUSY SHALL be 1 in UP_WAIT, UP_HOLD, DN_ISO and DN_WAIT; ERR SHALL be 1 only in ERROR.
REQ-009 OFF SHALL go to UP_WAIT when REQ=1, with CNT cleared to 0.
REQ-010 UP_WAIT transitions SHALL be:
- ACK=1: go to UP_HOLD, CNT cleared.
- ACK=0 and CNT=ACK_TIMEOUT-1: go to ERROR.
- otherwise: CNT increments.
REQ-011 UP_HOLD SHALL go to ON when CNT=ISO_HOLD-1, and increment CNT otherwise.
REQ-012 ON SHALL go to DN_ISO when REQ=0, with CNT cleared.
REQ-013 DN_ISO SHALL go to DN_WAIT when CNT=ISO_SETUP-1, with CNT cleared.
REQ-014 DN_WAIT transitions SHALL be:
- ACK=0: go to OFF.
- CNT=ACK_TIMEOUT-1: go to ERROR.
- otherwise: CNT increments.
REQ-015 ERROR SHALL go to OFF only when CLR_ERR=1 and ACK=0; CLR_ERR is ignored in every other state.
REQ-016 A REQ change during any transition state SHALL NOT abort it; the sequence completes, and REQ is re-evaluated in ON or OFF.
- Example: a drop during UP_WAIT gives ON for 1 cycle, then DN_ISO.
REQ-017 ISO SHALL never be 0 while PWR_EN=0 or while ACK is unconfirmed; a de-isolated domain implies PWR_EN=1 and ACK seen.
REQ-018 In ON, loss of ACK SHALL force ERROR in the next cycle, so ISO=1 within 1 cycle.
REQ-019 Simultaneous events SHALL resolve in this priority order: RST, then ACK timeout or ACK loss, then normal transition.
REQ-020 CNT SHALL never wrap; it saturates at its compare value.

Reset
REQ-021 RST=1 at any edge, including mid-sequence, SHALL force both domains to OFF with CNT=0.
- Resulting outputs: ISOB=ISOC=1, PWR_EN_B=PWR_EN_C=0, ON_B=ON_C=0, BUSY=ERR=2'b00.
REQ-022 These safe values SHALL also hold in the first cycle after RST is released.

Structure
REQ-023 Package iso_pwr_pkg SHALL hold the state enum, the CNT width (8) and the default parameter constants.
REQ-024 Sub-module iso_dom_fsm SHALL implement one domain (FSM, counter and output registers) and SHALL be instantiated twice, once for B and once for C; the top only wires them together.

Verification
REQ-025 The bench SHALL cover these directed scenarios, all at defaults:
- Power-up B: PWR_REQ_B 0->1, ACK_B returns 3 cycles after PWR_EN_B -> ISOB falls exactly 4 cycles after ACK_B is sampled, and ON_B=1 in the same cycle.
- Power-down B: PWR_REQ_B 1->0 in ON -> ISOB=1 the next cycle, PWR_EN_B falls 4 cycles later, and OFF is reached on ACK_B=0.
- Timeout: PWR_REQ_C=1 with ACK_C held 0 -> ERR[1]=1 after 200 cycles in UP_WAIT, PWR_EN_C=0, ISOC=1. A CLR_ERR pulse then returns the domain to OFF, and ERR[1]=0.
- ACK loss: ACK_B dropped while ON_B=1 -> next cycle ERR[0]=1 and ISOB=1; domain C is unaffected.
- Reset mid-sequence: RST pulsed while domain B is in UP_HOLD and domain C is in DN_ISO -> all outputs take their safe values at the next edge.
- Request bounce: PWR_REQ_B 1->0 during UP_WAIT -> full up sequence, ON_B=1 for 1 cycle, then a full down sequence; ISOB is never 0 while PWR_EN_B=0.

Source files
------------

// File: rtl/iso_pwr_pkg.sv
// iso_pwr_pkg: shared types and constants
// for the two-domain isolation/power sequencer.
package iso_pwr_pkg;

  localparam int CNT_W           = 8;
  localparam int ISO_SETUP_DEF   = 4;
  localparam int ISO_HOLD_DEF    = 4;
  localparam int ACK_TIMEOUT_DEF = 200;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_UP_WAIT = 3'd1,
    ST_UP_HOLD = 3'd2,
    ST_ON      = 3'd3,
    ST_DN_ISO  = 3'd4,
    ST_DN_WAIT = 3'd5,
    ST_ERROR   = 3'd6
  } dom_state_e;

  typedef struct packed {
    logic iso;
    logic pwr_en;
    logic on;
    logic busy;
    logic err;
  } dom_out_t;

  // Output pattern owned by each state.
  function automatic dom_out_t state_outs(
    input dom_state_e s
  );
    dom_out_t o;
    o = '{iso: 1'b1, pwr_en: 1'b0,
          on: 1'b0, busy: 1'b0,
          err: 1'b0};
    unique case (s)
      ST_UP_WAIT,
      ST_UP_HOLD,
      ST_DN_ISO: begin
        o.pwr_en = 1'b1;
        o.busy   = 1'b1;
      end
      ST_ON: begin
        o.iso    = 1'b0;
        o.pwr_en = 1'b1;
        o.on     = 1'b1;
      end
      ST_DN_WAIT: o.busy = 1'b1;
      ST_ERROR:   o.err  = 1'b1;
      default:    ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/iso_dom_fsm.sv
// iso_dom_fsm: one power domain sequencer
// with counter and registered outputs.
module iso_dom_fsm
  import iso_pwr_pkg::*;
#(
  parameter int ISO_SETUP   = ISO_SETUP_DEF,
  parameter int ISO_HOLD    = ISO_HOLD_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ack,
  input  logic clr_err,
  output logic iso,
  output logic pwr_en,
  output logic on,
  output logic busy,
  output logic err
);

  localparam logic [CNT_W-1:0] SETUP_M1 =
    CNT_W'(ISO_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_M1 =
    CNT_W'(ISO_HOLD - 1);
  localparam logic [CNT_W-1:0] TO_M1 =
    CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE =
    CNT_W'(1);

  dom_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dom_out_t         outs_q, outs_d;

  // Next state and counter; ack faults
  // outrank the normal sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_OFF: begin
        if (req) begin
          state_d = ST_UP_WAIT;
          cnt_d   = '0;
        end
      end
      ST_UP_WAIT: begin
        if (ack) begin
          state_d = ST_UP_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == TO_M1) begin
          state_d = ST_ERROR;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_UP_HOLD: begin
        if (cnt_q == HOLD_M1) begin
          state_d = ST_ON;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_ON: begin
        if (!ack) begin
          state_d = ST_ERROR;
        end else if (!req) begin
          state_d = ST_DN_ISO;
          cnt_d   = '0;
        end
      end
      ST_DN_ISO: begin
        if (cnt_q == SETUP_M1) begin
          state_d = ST_DN_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_DN_WAIT: begin
        if (!ack) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else if (cnt_q == TO_M1) begin
          state_d = ST_ERROR;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_ERROR: begin
        if (clr_err && !ack) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase
    outs_d = state_outs(state_d);
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      outs_q  <= state_outs(ST_OFF);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      outs_q  <= outs_d;
    end
  end

  assign iso    = outs_q.iso;
  assign pwr_en = outs_q.pwr_en;
  assign on     = outs_q.on;
  assign busy   = outs_q.busy;
  assign err    = outs_q.err;

endmodule

// File: rtl/iso_pwr_ctrl.sv
// iso_pwr_ctrl: two independent domain
// sequencers, B and C, wired side by side.
module iso_pwr_ctrl
  import iso_pwr_pkg::*;
#(
  parameter int ISO_SETUP   = ISO_SETUP_DEF,
  parameter int ISO_HOLD    = ISO_HOLD_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PWR_REQ_B,
  input  logic       PWR_REQ_C,
  input  logic       PWR_ACK_B,
  input  logic       PWR_ACK_C,
  input  logic       CLR_ERR,
  output logic       ISOB,
  output logic       ISOC,
  output logic       PWR_EN_B,
  output logic       PWR_EN_C,
  output logic       ON_B,
  output logic       ON_C,
  output logic [1:0] BUSY,
  output logic [1:0] ERR
);

  logic busy_b, busy_c;
  logic err_b, err_c;

  iso_dom_fsm #(
    .ISO_SETUP  (ISO_SETUP),
    .ISO_HOLD   (ISO_HOLD),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_dom_b (
    .clk    (CLK),
    .rst    (RST),
    .req    (PWR_REQ_B),
    .ack    (PWR_ACK_B),
    .clr_err(CLR_ERR),
    .iso    (ISOB),
    .pwr_en (PWR_EN_B),
    .on     (ON_B),
    .busy   (busy_b),
    .err    (err_b)
  );

  iso_dom_fsm #(
    .ISO_SETUP  (ISO_SETUP),
    .ISO_HOLD   (ISO_HOLD),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_dom_c (
    .clk    (CLK),
    .rst    (RST),
    .req    (PWR_REQ_C),
    .ack    (PWR_ACK_C),
    .clr_err(CLR_ERR),
    .iso    (ISOC),
    .pwr_en (PWR_EN_C),
    .on     (ON_C),
    .busy   (busy_c),
    .err    (err_c)
  );

  assign BUSY = {busy_c, busy_b};
  assign ERR  = {err_c, err_b};

endmodule

// File: tb/tb_iso_pwr_ctrl.sv
// tb_iso_pwr_ctrl: directed scenarios plus
// random traffic against a phase/age model.
module tb_iso_pwr_ctrl;

  localparam int SETUP = 4;
  localparam int HOLD  = 4;
  localparam int TOUT  = 200;

  // model phases
  localparam int P_OFF = 0;
  localparam int P_UPW = 1;
  localparam int P_UPH = 2;
  localparam int P_ON  = 3;
  localparam int P_DNI = 4;
  localparam int P_DNW = 5;
  localparam int P_ERR = 6;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       PWR_REQ_B = 1'b0;
  logic       PWR_REQ_C = 1'b0;
  logic       PWR_ACK_B = 1'b0;
  logic       PWR_ACK_C = 1'b0;
  logic       CLR_ERR = 1'b0;
  logic       ISOB, ISOC;
  logic       PWR_EN_B, PWR_EN_C;
  logic       ON_B, ON_C;
  logic [1:0] BUSY, ERR;

  int checks = 0;
  int errors = 0;

  int m_ph[2];
  int m_age[2];

  iso_pwr_ctrl dut (
    .CLK      (CLK),
    .RST      (RST),
    .PWR_REQ_B(PWR_REQ_B),
    .PWR_REQ_C(PWR_REQ_C),
    .PWR_ACK_B(PWR_ACK_B),
    .PWR_ACK_C(PWR_ACK_C),
    .CLR_ERR  (CLR_ERR),
    .ISOB     (ISOB),
    .ISOC     (ISOC),
    .PWR_EN_B (PWR_EN_B),
    .PWR_EN_C (PWR_EN_C),
    .ON_B     (ON_B),
    .ON_C     (ON_C),
    .BUSY     (BUSY),
    .ERR      (ERR)
  );

  always #5 CLK = ~CLK;

  // Advance one domain by the sequencing
  // rules; age = edges spent in the phase.
  task automatic model_dom(
    input int d, input bit rq,
    input bit ak, input bit clr
  );
    int ph, ag;
    ph = m_ph[d];
    ag = m_age[d] + 1;
    if (RST) begin
      ph = P_OFF; ag = 0;
    end else begin
      case (ph)
        P_OFF:
          if (rq) begin ph = P_UPW; ag = 0; end
        P_UPW:
          if (ak) begin ph = P_UPH; ag = 0; end
          else if (ag == TOUT) ph = P_ERR;
        P_UPH:
          if (ag == HOLD) ph = P_ON;
        P_ON:
          if (!ak) ph = P_ERR;
          else if (!rq) begin
            ph = P_DNI; ag = 0;
          end
        P_DNI:
          if (ag == SETUP) begin
            ph = P_DNW; ag = 0;
          end
        P_DNW:
          if (!ak) begin ph = P_OFF; ag = 0; end
          else if (ag == TOUT) ph = P_ERR;
        default:
          if (clr && !ak) begin
            ph = P_OFF; ag = 0;
          end
      endcase
    end
    m_ph[d]  = ph;
    m_age[d] = ag;
  endtask

  task automatic tick();
    model_dom(0, PWR_REQ_B, PWR_ACK_B, CLR_ERR);
    model_dom(1, PWR_REQ_C, PWR_ACK_C, CLR_ERR);
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [9:0] model_outs();
    logic [1:0] iso, pen, on, bsy, er;
    for (int d = 0; d < 2; d++) begin
      iso[d] = (m_ph[d] != P_ON);
      pen[d] = (m_ph[d] inside
                {P_UPW, P_UPH, P_ON, P_DNI});
      on[d]  = (m_ph[d] == P_ON);
      bsy[d] = (m_ph[d] inside
                {P_UPW, P_UPH, P_DNI, P_DNW});
      er[d]  = (m_ph[d] == P_ERR);
    end
    return {iso, pen, on, bsy, er};
  endfunction

  function automatic logic [9:0] dut_outs();
    return {ISOC, ISOB, PWR_EN_C, PWR_EN_B,
            ON_C, ON_B, BUSY, ERR};
  endfunction

  task automatic do_reset();
    PWR_REQ_B = 0; PWR_REQ_C = 0;
    PWR_ACK_B = 0; PWR_ACK_C = 0;
    CLR_ERR = 0;
    RST = 1;
    tick(); tick();
    RST = 0;
  endtask

  task automatic test_reset();
    logic [9:0] safe;
    safe = 10'b11_00_00_00_00;
    do_reset();
    checks++;
    if (dut_outs() !== safe) begin
      errors++;
      $display("FAIL reset_state got=%b exp=%b",
               dut_outs(), safe);
    end
    tick();
    checks++;
    if (dut_outs() !== safe) begin
      errors++;
      $display("FAIL post_reset got=%b exp=%b",
               dut_outs(), safe);
    end
  endtask

  task automatic bring_up(
    input bit b, input bit c, input string nm
  );
    bit ok;
    ok = 0;
    if (b) begin PWR_REQ_B = 1; PWR_ACK_B = 1; end
    if (c) begin PWR_REQ_C = 1; PWR_ACK_C = 1; end
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      ok = (!b || ON_B) && (!c || ON_C);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_bring_up got=%b%b exp=%b%b",
               nm, ON_C, ON_B, c, b);
    end
  endtask

  task automatic test_power_up_b();
    do_reset();
    PWR_REQ_B = 1;
    tick();
    checks++;
    if ({ISOB, PWR_EN_B, BUSY[0]} !== 3'b111) begin
      errors++;
      $display("FAIL up_enable got=%b exp=111",
               {ISOB, PWR_EN_B, BUSY[0]});
    end
    tick(); tick();
    PWR_ACK_B = 1;
    tick();
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if ({ISOB, ON_B} !== 2'b10) begin
        errors++;
        $display("FAIL up_hold%0d got=%b exp=10",
                 k, {ISOB, ON_B});
      end
    end
    tick();
    checks++;
    if ({ISOB, ON_B, PWR_EN_B, BUSY[0]}
        !== 4'b0110) begin
      errors++;
      $display("FAIL up_on got=%b exp=0110",
               {ISOB, ON_B, PWR_EN_B, BUSY[0]});
    end
  endtask

  task automatic test_power_down_b();
    PWR_REQ_B = 0;
    tick();
    checks++;
    if ({ISOB, ON_B, PWR_EN_B} !== 3'b101) begin
      errors++;
      $display("FAIL dn_iso got=%b exp=101",
               {ISOB, ON_B, PWR_EN_B});
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (PWR_EN_B !== 1'b1) begin
        errors++;
        $display("FAIL dn_setup%0d got=%b exp=1",
                 k, PWR_EN_B);
      end
    end
    tick();
    checks++;
    if ({PWR_EN_B, ISOB, BUSY[0]} !== 3'b011) begin
      errors++;
      $display("FAIL dn_wait got=%b exp=011",
               {PWR_EN_B, ISOB, BUSY[0]});
    end
    PWR_ACK_B = 0;
    tick();
    checks++;
    if ({ISOB, PWR_EN_B, BUSY[0], ERR[0]}
        !== 4'b1000) begin
      errors++;
      $display("FAIL dn_off got=%b exp=1000",
               {ISOB, PWR_EN_B, BUSY[0], ERR[0]});
    end
  endtask

  task automatic test_timeout();
    bit early;
    early = 0;
    do_reset();
    PWR_REQ_C = 1;
    tick();
    for (int k = 1; k < TOUT; k++) begin
      tick();
      if (ERR[1] !== 1'b0) early = 1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL to_early got=1 exp=0");
    end
    tick();
    checks++;
    if ({ERR, PWR_EN_C, ISOC, BUSY[1]}
        !== 5'b10010) begin
      errors++;
      $display("FAIL to_err got=%b exp=10010",
               {ERR, PWR_EN_C, ISOC, BUSY[1]});
    end
    PWR_REQ_C = 0;
    PWR_ACK_C = 1;
    CLR_ERR = 1;
    tick();
    CLR_ERR = 0;
    checks++;
    if (ERR[1] !== 1'b1) begin
      errors++;
      $display("FAIL clr_with_ack got=%b exp=1",
               ERR[1]);
    end
    PWR_ACK_C = 0;
    CLR_ERR = 1;
    tick();
    CLR_ERR = 0;
    checks++;
    if ({ERR, ISOC, PWR_EN_C, BUSY[1]}
        !== 5'b00100) begin
      errors++;
      $display("FAIL clr_off got=%b exp=00100",
               {ERR, ISOC, PWR_EN_C, BUSY[1]});
    end
  endtask

  task automatic test_ack_loss();
    do_reset();
    bring_up(1, 1, "loss");
    PWR_ACK_B = 0;
    tick();
    checks++;
    if ({ERR, ISOB, ON_B} !== 4'b0110) begin
      errors++;
      $display("FAIL loss_b got=%b exp=0110",
               {ERR, ISOB, ON_B});
    end
    checks++;
    if ({ON_C, ISOC, PWR_EN_C} !== 3'b101) begin
      errors++;
      $display("FAIL loss_c got=%b exp=101",
               {ON_C, ISOC, PWR_EN_C});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bring_up(0, 1, "mid");
    PWR_REQ_C = 0;
    PWR_REQ_B = 1;
    PWR_ACK_B = 1;
    tick(); tick();
    checks++;
    if ({BUSY, PWR_EN_C, PWR_EN_B}
        !== 4'b1111) begin
      errors++;
      $display("FAIL mid_pre got=%b exp=1111",
               {BUSY, PWR_EN_C, PWR_EN_B});
    end
    RST = 1;
    tick();
    checks++;
    if (dut_outs() !== 10'b11_00_00_00_00) begin
      errors++;
      $display("FAIL mid_rst got=%b exp=%b",
               dut_outs(), 10'b11_00_00_00_00);
    end
    RST = 0;
    PWR_REQ_B = 0;
    PWR_ACK_B = 0;
    PWR_ACK_C = 0;
  endtask

  task automatic test_bounce();
    int  on_cnt, viol;
    bit  seen_on, done;
    on_cnt = 0; viol = 0;
    seen_on = 0; done = 0;
    do_reset();
    PWR_REQ_B = 1;
    tick();
    PWR_REQ_B = 0;
    tick();
    PWR_ACK_B = 1;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (!PWR_EN_B && !ISOB) viol++;
      if (ON_B) begin on_cnt++; seen_on = 1; end
      if (!PWR_EN_B && BUSY[0]) PWR_ACK_B = 0;
      if (seen_on && !BUSY[0] && !ON_B)
        done = 1;
    end
    checks++;
    if (!done || ERR[0]) begin
      errors++;
      $display("FAIL bounce_end got=%b%b exp=10",
               done, ERR[0]);
    end
    checks++;
    if (on_cnt != 1) begin
      errors++;
      $display("FAIL bounce_on got=%0d exp=1",
               on_cnt);
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL bounce_iso got=%0d exp=0",
               viol);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      RST = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 29) == 0)
        PWR_REQ_B = ~PWR_REQ_B;
      if ($urandom_range(0, 29) == 0)
        PWR_REQ_C = ~PWR_REQ_C;
      PWR_ACK_B = PWR_EN_B
        ? ($urandom_range(0, 24) != 0)
        : ($urandom_range(0, 24) == 0);
      PWR_ACK_C = PWR_EN_C
        ? ($urandom_range(0, 24) != 0)
        : ($urandom_range(0, 24) == 0);
      CLR_ERR = ($urandom_range(0, 14) == 0);
      tick();
      checks++;
      if (dut_outs() !== model_outs()) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL rand_%0d got=%b exp=%b",
                   i, dut_outs(), model_outs());
      end
    end
    RST = 0;
    CLR_ERR = 0;
  endtask

  initial begin
    test_reset();
    test_power_up_b();
    test_power_down_b();
    test_timeout();
    test_ack_loss();
    test_reset_mid();
    test_bounce();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
